// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the matrix keypad scanner.
//   kp_state_e - scanner FSM states
//   KEY_*      - codes of the calculator function keys
//   clog2()    - ceiling log2, usable in constant expressions
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_PRESS_DB,
    ST_HELD,
    ST_RELEASE_DB
  } kp_state_e;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQU = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/keypad_fifo.sv
// keypad_fifo: small synchronous FIFO that buffers key events.
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   push_i, data_i  - write request and data (ignored when full, unless popping)
//   pop_i           - read request (ignored when empty)
//   data_o          - head entry, valid while empty_o is low
//   full_o, empty_o - occupancy flags
// DEPTH must be a power of two so the pointers wrap on their own.
module keypad_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-strobed matrix keypad scanner with debounce and event FIFO.
//   clk, rst_n - clock, asynchronous active-low reset
//   row_drive  - active-low row strobe (one row low while scanning)
//   col_sense  - active-low column returns, asynchronous
//   code       - key code at FIFO head (row*COLS+col), 0 when empty
//   press      - FIFO non-empty; ack pops the head
//   overflow   - sticky, an event was dropped on a full FIFO
//   key_held   - a debounced key is down
// Optional macro KEYPAD_AUTOREPEAT_EN adds auto-repeat while a key is held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned SCAN_CYCLES     = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH      = 4
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 256,
  parameter int unsigned REPEAT_RATE     = 64
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [ROWS-1:0]               row_drive,
  input  logic [COLS-1:0]               col_sense,
  output logic [clog2(ROWS*COLS)-1:0]   code,
  output logic                          press,
  input  logic                          ack,
  output logic                          overflow,
  output logic                          key_held
);

  localparam int unsigned CODE_W = clog2(ROWS * COLS);
  localparam int unsigned RW     = clog2(ROWS);
  localparam int unsigned CW     = clog2(COLS);
  localparam int unsigned SW     = clog2(SCAN_CYCLES);
  localparam int unsigned DW     = clog2(DEBOUNCE_CYCLES + 1);

  kp_state_e         state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [DW-1:0]     db_cnt_q, db_cnt_d;
  logic [ROWS-1:0]   row_drive_q;
  logic [COLS-1:0]   col_meta_q, col_sync_q;
  logic              overflow_q;
  logic              any_low, latched_low, push;
  logic [CW-1:0]     low_col;
  logic [CODE_W-1:0] new_code, head_code;
  logic              fifo_full, fifo_empty;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RPW = clog2(REPEAT_DELAY + REPEAT_RATE);
  logic [RPW-1:0] rep_cnt_q, rep_cnt_d;
  logic           rep_first_q, rep_first_d;
`endif

  always_comb begin
    any_low = 1'b0;
    low_col = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (!col_sync_q[c] && !any_low) begin
        any_low = 1'b1;
        low_col = CW'(c);
      end
    end
  end

  assign latched_low = !col_sync_q[col_q];
  assign new_code    = CODE_W'(row_q * COLS + col_q);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    scan_cnt_d = scan_cnt_q;
    db_cnt_d   = db_cnt_q;
    push       = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_d   = '0;
    rep_first_d = 1'b0;
`endif
    case (state_q)
      ST_SCAN: begin
        // The first two samples of a row slot still reflect the previous
        // row through the synchroniser, so they are not trusted.
        if (scan_cnt_q >= SW'(2) && any_low) begin
          state_d    = ST_PRESS_DB;
          col_d      = low_col;
          db_cnt_d   = '0;
          scan_cnt_d = '0;
        end else if (scan_cnt_q == SW'(SCAN_CYCLES - 1)) begin
          scan_cnt_d = '0;
          row_d      = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      ST_PRESS_DB: begin
        if (db_cnt_q == DW'(DEBOUNCE_CYCLES)) begin
          push     = 1'b1;
          state_d  = ST_HELD;
          db_cnt_d = '0;
        end else if (latched_low) begin
          db_cnt_d = db_cnt_q + 1'b1;
        end else begin
          state_d    = ST_SCAN;
          scan_cnt_d = '0;
          db_cnt_d   = '0;
        end
      end
      ST_HELD: begin
        if (!latched_low) begin
          state_d  = ST_RELEASE_DB;
          db_cnt_d = '0;
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_first_d = rep_first_q;
          if (rep_cnt_q == RPW'(rep_first_q ? REPEAT_RATE - 1 : REPEAT_DELAY - 1)) begin
            push        = 1'b1;
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
`endif
        end
      end
      ST_RELEASE_DB: begin
        if (latched_low) begin
          state_d  = ST_HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          state_d    = ST_SCAN;
          row_d      = '0;
          scan_cnt_d = '0;
          db_cnt_d   = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      row_q       <= '0;
      col_q       <= '0;
      scan_cnt_q  <= '0;
      db_cnt_q    <= '0;
      row_drive_q <= '1;
      col_meta_q  <= '1;
      col_sync_q  <= '1;
      overflow_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      scan_cnt_q  <= scan_cnt_d;
      db_cnt_q    <= db_cnt_d;
      row_drive_q <= ~(ROWS'(1) << row_d);
      col_meta_q  <= col_sense;
      col_sync_q  <= col_meta_q;
      // A full FIFO always has a head, so ack alone means a pop this cycle.
      overflow_q  <= overflow_q | (push && fifo_full && !ack);
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
`endif
    end
  end

  keypad_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .pop_i   (ack),
    .data_i  (new_code),
    .data_o  (head_code),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign row_drive = row_drive_q;
  assign press     = !fifo_empty;
  assign code      = fifo_empty ? '0 : head_code;
  assign overflow  = overflow_q;
  assign key_held  = (state_q == ST_HELD) || (state_q == ST_RELEASE_DB);

endmodule
